// File: rtl/mult_pkg.sv
// Shared definitions for the multiply-accumulate datapath: operand and
// accumulator widths plus the accumulator FSM state encoding.
package mult_pkg;

  // Width of one unsigned product from the 4x4 multiplier stage.
  localparam int PROD_W = 8;
  // Accumulator width: 16 * 225 = 3600 fits in 12 bits, so no overflow handling.
  localparam int ACC_W  = 12;
  // Product counter width: must hold 0..16.
  localparam int CNT_W  = 5;

  // ACCUM: collecting products. DONE: holding a finished result for the consumer.
  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } acc_state_t;

endpackage : mult_pkg

// File: rtl/mult_accumulator.sv
// Sums N_PROD unsigned products into a 12-bit result using valid/ready
// handshakes on both sides. A result is presented one cycle after its last
// product. It is held until the consumer takes it. 'clear' abandons the
// accumulation in progress.
module mult_accumulator
  import mult_pkg::*;
#(
  parameter int unsigned N_PROD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  sum,
  output logic [CNT_W-1:0]  count
);

  // Count value held before the product that completes a result.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PROD - 1);

  acc_state_t       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  // FSM, accumulator and counter. clear takes priority over both handshakes.
  // NOTE: all state is reset asynchronously so that a pending partial sum or
  // result disappears the moment rst rises, not at the next clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every branch sees the pre-edge
      // values of acc and cnt, not values updated earlier in this block.
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc <= acc + ACC_W'(product);
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          // The result is frozen here. A product offered in the release
          // cycle is not taken because in_ready is still low.
          if (out_ready) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ACCUM;
          acc       <= '0;
          cnt       <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // in_ready is decoded from the state register only. It has no path from in_valid.
  assign in_ready = (state == ACCUM);
  assign sum      = acc;
  assign count    = cnt;

endmodule : mult_accumulator

// File: tb/tb_mult_accumulator.sv
// Directed bench for mult_accumulator. It uses three instances: N_PROD=4 (idx 0),
// N_PROD=16 (idx 1) and N_PROD=1 (idx 2). Each expected result is queued when its
// last product is driven. The queue entry is compared when the result is taken.
module tb_mult_accumulator;

  logic        clk;
  logic        rst;
  logic        clear     [3];
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [7:0]  product   [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [11:0] sum       [3];
  logic [4:0]  count     [3];

  logic [11:0] exp_q [3][$];

  int n_tests = 0;
  int n_fail  = 0;

  mult_accumulator #(.N_PROD(4)) u_acc4 (
    .clk(clk), .rst(rst), .clear(clear[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .product(product[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .sum(sum[0]), .count(count[0])
  );

  mult_accumulator #(.N_PROD(16)) u_acc16 (
    .clk(clk), .rst(rst), .clear(clear[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .product(product[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .sum(sum[1]), .count(count[1])
  );

  mult_accumulator #(.N_PROD(1)) u_acc1 (
    .clk(clk), .rst(rst), .clear(clear[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .product(product[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .sum(sum[2]), .count(count[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge once the inputs are set. It scores any output
  // transfer the next rising edge will make, then moves to the next falling edge.
  task automatic tick();
    logic [11:0] e;
    for (int i = 0; i < 3; i++) begin
      if (out_valid[i] === 1'b1 && out_ready[i] === 1'b1) begin
        check($sformatf("result_expected_u%0d", i), 32'(exp_q[i].size() == 0), 32'd0);
        if (exp_q[i].size() != 0) begin
          e = exp_q[i].pop_front();
          check($sformatf("result_sum_u%0d", i), 32'(sum[i]), 32'(e));
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_state(input string tag, input int i, input logic rdy,
                             input logic ov, input int s, input int c);
    check({tag, "_in_ready"},  32'(in_ready[i]),  32'(rdy));
    check({tag, "_out_valid"}, 32'(out_valid[i]), 32'(ov));
    check({tag, "_sum"},       32'(sum[i]),       32'(s));
    check({tag, "_count"},     32'(count[i]),     32'(c));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      clear[i] = 1'b0; in_valid[i] = 1'b0; product[i] = 8'd0; out_ready[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state on every instance
    for (int i = 0; i < 3; i++) check_state($sformatf("reset_u%0d", i), i, 1'b1, 1'b0, 0, 0);

    // Four back-to-back products of 156 with the consumer always ready
    out_ready[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid[0] = 1'b1; product[0] = 8'd156;
      if (k == 3) exp_q[0].push_back(12'd624);
      tick();
      if (k == 2) check_state("b2b_after3", 0, 1'b1, 1'b0, 468, 3);
    end
    check_state("b2b_done", 0, 1'b0, 1'b1, 624, 4);
    in_valid[0] = 1'b0; product[0] = 8'hxx;
    tick();
    check_state("b2b_release", 0, 1'b1, 1'b0, 0, 0);

    // Gapped products 10,20,30,40; consumer stalls for 5 cycles
    out_ready[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid[0] = 1'b1; product[0] = 8'(10 * (k + 1));
      if (k == 3) exp_q[0].push_back(12'd100);
      tick();
      if (k != 3) begin
        in_valid[0] = 1'b0; product[0] = 8'hxx;
        tick();
      end
    end
    in_valid[0] = 1'b1; product[0] = 8'd200;
    for (int k = 0; k < 5; k++) begin
      check_state($sformatf("stall_c%0d", k), 0, 1'b0, 1'b1, 100, 4);
      tick();
    end
    out_ready[0] = 1'b1;
    tick();
    check_state("stall_release", 0, 1'b1, 1'b0, 0, 0);
    in_valid[0] = 1'b0;

    // clear with a simultaneous product discards the partial sum and that product
    for (int k = 0; k < 2; k++) begin
      in_valid[0] = 1'b1; product[0] = 8'd50;
      tick();
    end
    check_state("clear_before", 0, 1'b1, 1'b0, 100, 2);
    clear[0] = 1'b1; in_valid[0] = 1'b1; product[0] = 8'd99;
    tick();
    clear[0] = 1'b0;
    check_state("clear_after", 0, 1'b1, 1'b0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      in_valid[0] = 1'b1; product[0] = 8'd1;
      if (k == 3) exp_q[0].push_back(12'd4);
      tick();
    end
    check_state("clear_resume_done", 0, 1'b0, 1'b1, 4, 4);
    in_valid[0] = 1'b0;
    tick();

    // Asynchronous reset while a result of 624 is held
    out_ready[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid[0] = 1'b1; product[0] = 8'd156;
      tick();
    end
    in_valid[0] = 1'b0;
    check_state("rst_before", 0, 1'b0, 1'b1, 624, 4);
    #3 rst = 1'b1;
    #1 check_state("rst_async", 0, 1'b1, 1'b0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_state("rst_release", 0, 1'b1, 1'b0, 0, 0);
    out_ready[0] = 1'b1;
    tick();
    check("rst_no_stale_result", 32'(out_valid[0]), 32'd0);
    out_ready[0] = 1'b0;

    // N_PROD=16, 225 every cycle reaches 3600 without overflow
    out_ready[1] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_valid[1] = 1'b1; product[1] = 8'd225;
      if (k == 15) exp_q[1].push_back(12'd3600);
      tick();
    end
    in_valid[1] = 1'b0;
    check_state("max_done", 1, 1'b0, 1'b1, 3600, 16);
    tick();
    check_state("max_release", 1, 1'b1, 1'b0, 0, 0);

    // N_PROD=1, continuous stream 7,8,9: one in_ready=0 cycle after each result
    out_ready[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[2] = 1'b1; product[2] = 8'(7 + k);
      check($sformatf("single_ready_%0d", k), 32'(in_ready[2]), 32'd1);
      exp_q[2].push_back(12'(7 + k));
      tick();
      check_state($sformatf("single_done_%0d", k), 2, 1'b0, 1'b1, 7 + k, 1);
      tick();
    end
    in_valid[2] = 1'b0;
    check_state("single_idle", 2, 1'b1, 1'b0, 0, 0);

    // Every queued result must have been taken
    for (int i = 0; i < 3; i++)
      check($sformatf("queue_drained_u%0d", i), 32'(exp_q[i].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mult_accumulator

// File: doc/mult_accumulator.md
MULT_ACCUMULATOR -- requirements
Module: mult_accumulator

Interface
REQ-001 SHALL have parameter N_PROD, default 4, number of products summed per result; legal range 1..16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port clear  input  1  synchronous abort of current accumulation.
REQ-005 SHALL have port in_valid  input  1  product present on `product`.
REQ-006 SHALL have port in_ready  output  1  block accepts a product this cycle.
REQ-007 SHALL have port product  input  8  unsigned product from the 4x4 multiplier stage.
REQ-008 SHALL have port out_valid  output  1  `sum` holds a completed result.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-010 SHALL have port sum  output  12  unsigned accumulated result.
REQ-011 SHALL have port count  output  5  products accepted in current accumulation, 0..N_PROD.

Function
REQ-012 SHALL implement FSM states ACCUM and DONE.
- Input transfer: in_valid && in_ready at a rising edge.
- Output transfer: out_valid && out_ready at a rising edge.
REQ-013 SHALL drive in_ready=1 in ACCUM and in_ready=0 in DONE; in_ready SHALL NOT depend combinationally on in_valid.
REQ-014 SHALL, in ACCUM on each input transfer, add zero-extended `product` to the 12-bit accumulator and increment count by 1.
REQ-015 SHALL move ACCUM->DONE on the input transfer that makes count equal N_PROD.
- sum and out_valid=1 visible the next cycle: latency 1 cycle after the last product.
REQ-016 SHALL hold sum, count and out_valid stable in DONE until an output transfer.
REQ-017 SHALL, on an output transfer, clear the accumulator and count to 0 and return to ACCUM.
- out_valid=0 and in_ready=1 the next cycle.
- No product is accepted in the same cycle as the output transfer.
REQ-018 SHALL drive out_valid=0 in ACCUM; sum SHALL show the running accumulator in ACCUM.
REQ-019 SHALL, when clear=1 at a rising edge in any state, set accumulator and count to 0 and enter ACCUM.
- clear overrides any simultaneous input or output transfer.
- The product offered that cycle is discarded.
REQ-020 SHALL size the accumulator at 12 bits, so 16x225=3600 never overflows; no saturation or wrap logic is required.
REQ-021 SHALL, with N_PROD=1, enter DONE after every single accepted product.
REQ-022 SHALL ignore `product` whenever no input transfer occurs, including X values.

Reset
REQ-023 SHALL, while rst=1, asynchronously force state=ACCUM, accumulator=0, count=0, out_valid=0 and sum=0.
REQ-024 SHALL drive in_ready=1 in the first cycle after rst deasserts.
REQ-025 SHALL, when rst asserts mid-accumulation or in DONE, discard the partial sum or pending result; no output transfer SHALL occur for it.

Structure
REQ-026 SHALL take PROD_W=8, ACC_W=12, CNT_W=5 and the FSM state encoding from shared package mult_pkg, which the multiplier stages also use.
REQ-027 SHALL be a single module with no sub-modules; accumulator, counter and FSM are inline.
REQ-028 SHALL register all outputs except in_ready, which SHALL be decoded from registered state only.

Verification
REQ-029 SHALL cover: N_PROD=4, product=156 (12x13) on 4 consecutive cycles, out_ready=1 -> out_valid 1 cycle after 4th, sum=624 (0x270), count=4, then ACCUM with sum=0.
REQ-030 SHALL cover: N_PROD=4, products 10,20,30,40 with in_valid gaps, out_ready=0 for 5 cycles -> sum=100 held stable, in_ready=0 throughout, released on out_ready=1.
REQ-031 SHALL cover: N_PROD=16, product=225 every cycle -> sum=3600 (0xE10), no overflow.
REQ-032 SHALL cover: N_PROD=4, 2 products of 50, then clear=1 together with in_valid=1, product=99 -> count=0, sum=0; next 4 products of 1 give sum=4.
REQ-033 SHALL cover: rst pulse asynchronous to clk during DONE with sum=624 -> out_valid=0 and sum=0 immediately, in_ready=1 after release.
REQ-034 SHALL cover: N_PROD=1, stream 7,8,9 with out_ready=1 -> three results 7,8,9, each followed by one in_ready=0 cycle.
